key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of independent key channels, 1..32.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 1000: consecutive cycles the input must stay opposite to the debounced level before the level flips; at least 1.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 50000: cycles of debounced-high before the long_press pulse; at least 1.
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 10000: auto-repeat period after long_press; 0 disables repeat.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  N_CH  raw asynchronous key inputs, active-high.
REQ-008 level  output  N_CH  debounced key level.
REQ-009 rise  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-010 fall  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-011 change  output  N_CH  rise OR fall.
REQ-012 long_press  output  N_CH  one-cycle pulse when held for HOLD_CYCLES.
REQ-013 repeat_p  output  N_CH  one-cycle auto-repeat pulse while held past HOLD_CYCLES.

Function
REQ-014 Each key_in bit SHALL pass a 2-flop synchroniser; sync value = second flop.
REQ-015 Per channel, the debounce counter SHALL clear whenever sync equals level and increment otherwise.
REQ-016 When sync differs from level and the counter equals DEB_CYCLES-1, level SHALL invert at that edge and the counter SHALL clear.
REQ-017 Latency: a clean key_in step first sampled at edge E SHALL change level at edge E+1+DEB_CYCLES.
REQ-018 A disturbance shorter than DEB_CYCLES synchronised cycles SHALL NOT change level; any return to the level value restarts the count.
REQ-019 rise, fall, change SHALL be registered, asserted in exactly the cycle level first shows its new value, for one cycle.
REQ-020 Hold counter SHALL clear while level is 0 and increment while level is 1, saturating at its all-ones value.
REQ-021 long_press SHALL pulse for one cycle when the hold counter reaches HOLD_CYCLES, at most once per press.
REQ-022 With REPEAT_CYCLES>0, repeat_p SHALL pulse every REPEAT_CYCLES cycles after long_press while level stays 1; first repeat at HOLD_CYCLES+REPEAT_CYCLES.
REQ-023 Repeat SHALL continue indefinitely for an unbounded hold; the repeat phase counter wraps, not the saturated hold counter.
REQ-024 A fall SHALL immediately cancel pending long_press/repeat; no pulse in or after the fall cycle.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels all reported in the same cycle.
REQ-026 Counter widths SHALL be ceil(log2(max(DEB_CYCLES,HOLD_CYCLES,REPEAT_CYCLES)+1)), so no counter overflows before its terminal value.

Reset
REQ-027 On rst_n low, all synchroniser flops, counters, level and every output SHALL go to 0 asynchronously.
REQ-028 After rst_n deasserts with key_in held 1, level SHALL rise per REQ-017 and rise SHALL pulse; no spurious fall.
REQ-029 Reset asserted mid-press or mid-debounce SHALL discard all progress; no pulse emitted during or on exit from reset.

Structure
REQ-030 Package key_cond_pkg SHALL hold the default parameter constants and the counter-width function.
REQ-031 One sub-module key_cond_ch (single channel: synchroniser, debounce, edge, hold/repeat) SHALL be instantiated N_CH times by a generate loop.

Verification (N_CH=2, DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-032 key_in[0] 0->1 stable, first sampled at edge 10 -> level[0]=1 and rise[0]=change[0]=1 at edge 15 only.
REQ-033 key_in[0] high for 3 cycles, then low -> level, rise, fall stay 0.
REQ-034 Bounce 1,0,1,1,1,1 -> count restarts at the 0; level rises 4 cycles after the last return to 1 reaches sync.
REQ-035 Hold key_in[1] for 60 cycles after level rises -> long_press[1] at +20, repeat_p[1] at +28, +36, +44, +52; release -> fall[1], no further pulses.
REQ-036 Both channels stepped in the same cycle -> rise[1:0]=2'b11 in one cycle; rst_n pulsed low mid-hold -> all outputs 0 at once, no long_press afterwards until a new 20-cycle hold.

Source files
------------

// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - default timing constants and counter sizing for the key conditioner
package key_cond_pkg;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_DEB_CYCLES    = 1000;
    localparam int DEF_HOLD_CYCLES   = 50000;
    localparam int DEF_REPEAT_CYCLES = 10000;

    // One width shared by every per-channel counter, wide enough for the largest terminal value.
    function automatic int cnt_width(input int deb, input int hold, input int rep);
        int m;
        m = deb;
        if (hold > m) m = hold;
        if (rep > m) m = rep;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_cond_ch.sv
// rtl/key_cond_ch.sv - one key channel: synchroniser, debounce, edge pulses, long-press and auto-repeat
module key_cond_ch
    import key_cond_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic change,
    output logic long_press,
    output logic repeat_p
);

    localparam int             CW        = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0]  DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_TGT  = CW'(HOLD_CYCLES);
    localparam bit             REP_EN    = (REPEAT_CYCLES > 0);
    localparam logic [CW-1:0]  REP_LAST  = REP_EN ? CW'(REPEAT_CYCLES - 1) : '0;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          change_q, change_d;
    logic          long_press_q, long_press_d;
    logic          repeat_q, repeat_d;
    logic          held_long;
    logic          still_high;

    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;

        level_d   = level_q;
        deb_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) level_d = ~level_q;
            else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end

        rise_d   = level_d & ~level_q;
        fall_d   = ~level_d & level_q;
        change_d = rise_d | fall_d;

        // Hold count saturates; the repeat phase counter is the one that wraps.
        hold_cnt_d = '0;
        if (level_q) hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;

        held_long = level_q && (hold_cnt_q >= HOLD_TGT);
        rep_cnt_d = '0;
        if (held_long) rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;

        // A fall at this edge suppresses any pulse that would land with it.
        still_high   = level_q & level_d;
        long_press_d = still_high && (hold_cnt_q == HOLD_LAST);
        repeat_d     = still_high && REP_EN && held_long && (rep_cnt_q == REP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            change_q     <= 1'b0;
            long_press_q <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            change_q     <= change_d;
            long_press_q <= long_press_d;
            repeat_q     <= repeat_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign change     = change_q;
    assign long_press = long_press_q;
    assign repeat_p   = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N_CH independent debounced keys with edge, long-press and repeat pulses
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] key_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] change,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_cond_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_in    (key_in[i]),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .change    (change[i]),
            .long_press(long_press[i]),
            .repeat_p  (repeat_p[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner against a history-based reference model
module tb_key_conditioner;

    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_in = '0;
    logic [N-1:0] level, rise, fall, change, long_press, repeat_p;

    int n_cmp = 0;
    int n_err = 0;

    logic [6*N-1:0] exp_q[$];

    // Model state: every key sample since reset, and when each channel last rose.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lvl;
    int           m_t;
    int           m_rise_t[N];

    key_conditioner #(
        .N_CH         (N),
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .change    (change),
        .long_press(long_press),
        .repeat_p  (repeat_p)
    );

    always #5 clk = ~clk;

    // Level flips when the synchronised input (key sampled two edges back) has
    // disagreed with the level for the last DEB edges.
    always @(posedge clk) begin
        logic [N-1:0] r, f, lp, rp;
        bit   flip;
        logic v;
        int   held;
        r = '0; f = '0; lp = '0; rp = '0;
        if (!rst_n) begin
            hist.delete();
            m_t   = 0;
            m_lvl = '0;
            exp_q.push_back('0);
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                flip = 1'b1;
                for (int k = m_t - 1 - DEB; k <= m_t - 2; k++) begin
                    v = (k >= 0) ? hist[k][ch] : 1'b0;
                    if (v == m_lvl[ch]) flip = 1'b0;
                end
                if (flip) begin
                    m_lvl[ch] = ~m_lvl[ch];
                    if (m_lvl[ch]) begin
                        r[ch] = 1'b1;
                        m_rise_t[ch] = m_t;
                    end else begin
                        f[ch] = 1'b1;
                    end
                end
                if (m_lvl[ch]) begin
                    held   = m_t - m_rise_t[ch];
                    lp[ch] = (held == HOLD);
                    rp[ch] = (held > HOLD) && (((held - HOLD) % REP) == 0);
                end
            end
            hist.push_back(key_in);
            m_t++;
            exp_q.push_back({m_lvl, r, f, r | f, lp, rp});
        end
    end

    always @(negedge clk) begin
        logic [6*N-1:0] e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {level, rise, fall, change, long_press, repeat_p};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got lvl/ri/fa/ch/lp/rp=%b required=%b", $time, got, e);
            end
        end
    end

    task automatic run(input logic [N-1:0] v, input int n);
        key_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({level, rise, fall, change, long_press, repeat_p} !== '0) begin
            n_err++;
            $display("FAIL async_reset got=%b required=0", {level, rise, fall, change, long_press, repeat_p});
        end
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(2'b00, 6);
        run(2'b01, 32);
        run(2'b00, 10);
        run(2'b01, 3);
        run(2'b00, 10);
        run(2'b01, 1); run(2'b00, 1); run(2'b01, 12);
        run(2'b00, 10);
        run(2'b10, 70);
        run(2'b00, 15);
        run(2'b11, 14);
        pulse_reset(3);
        run(2'b11, 45);
        run(2'b00, 10);

        k = '0;
        repeat (700) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 29) == 0) k[ch] = ~k[ch];
            if ($urandom_range(0, 19) == 0) run(k ^ 2'(1 << $urandom_range(0, N - 1)), 1 + $urandom_range(0, 2));
            run(k, 1);
        end
        run(2'b11, 60);
        run(2'b00, 12);

        @(negedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
